// File: rtl/redmule_pkg.sv
// Shared RedMulE types: array geometry, FP format helpers, W-scheduler FSM state and job config.
// Consumed by redmule_w_sched (optional perf counter enabled by REDMULE_W_SCHED_PERF_EN).
package redmule_pkg;

  localparam int unsigned ARRAY_HEIGHT = 4;

  typedef enum logic [1:0] {
    FP8  = 2'd0,
    FP16 = 2'd1,
    FP32 = 2'd2
  } fp_format_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP8:     return 8;
      FP16:    return 16;
      FP32:    return 32;
      default: return 16;
    endcase
  endfunction

  // Config field widths match the scheduler's default geometry.
  localparam int unsigned CFG_CNT_W = 16;
  localparam int unsigned CFG_HGT_W = $clog2(ARRAY_HEIGHT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } w_sched_state_e;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] n_tiles;
    logic [CFG_HGT_W-1:0] last_height;
    logic [CFG_CNT_W-1:0] last_width;
  } w_sched_cfg_t;

endpackage

// File: rtl/redmule_w_sched.sv
// W-operand scheduler: fills H buffer rows per tile, then streams D shifts to the engine.
// Define REDMULE_W_SCHED_PERF_EN to build the saturating stall counter on stall_cnt_o.
module redmule_w_sched
  import redmule_pkg::*;
#(
  parameter int unsigned H     = ARRAY_HEIGHT,
  parameter int unsigned D     = 288 / fp_width(FP16),
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     n_tiles_i,
  input  logic [$clog2(H):0]   last_height_i,
  input  logic [CNT_W-1:0]     last_width_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 shift_req_i,
  output logic                 shift_gnt_o,
  output logic                 buf_load_o,
  output logic                 buf_shift_o,
  output logic                 buf_clear_o,
  output logic [$clog2(H):0]   buf_height_o,
  output logic [CNT_W-1:0]     buf_width_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          stall_cnt_o
);

  localparam int unsigned HW = $clog2(H) + 1;
  localparam int unsigned DW = $clog2(D) + 1;

  w_sched_state_e r_state;
  w_sched_cfg_t   r_cfg;
  logic [HW-1:0]    r_row_cnt;
  logic [DW-1:0]    r_shift_cnt;
  logic [CNT_W-1:0] r_tile_cnt;

  logic             w_fill;
  logic             w_stream;
  logic             w_start;
  logic             w_last_tile;
  logic [CNT_W-1:0] w_n_tiles;

  assign w_fill      = (r_state == FILL);
  assign w_stream    = (r_state == STREAM);
  assign w_start     = (r_state == IDLE) && start_i;
  assign w_n_tiles   = CNT_W'(r_cfg.n_tiles);
  assign w_last_tile = (r_tile_cnt == w_n_tiles - CNT_W'(1));

  // clear_i overrides any handshake in flight so the buffer never sees a half-accepted beat.
  assign w_ready_o    = w_fill && !clear_i;
  assign buf_load_o   = w_valid_i && w_ready_o;
  assign shift_gnt_o  = w_stream && shift_req_i && !clear_i;
  assign buf_shift_o  = shift_gnt_o;
  assign buf_clear_o  = clear_i || w_start;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE) && !clear_i;

  assign buf_height_o = !(w_fill || w_stream) ? '0 :
                        w_last_tile ? HW'(r_cfg.last_height) : HW'(H);
  assign buf_width_o  = !(w_fill || w_stream) ? '0 :
                        w_last_tile ? CNT_W'(r_cfg.last_width) : CNT_W'(D);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cfg       <= '0;
      r_row_cnt   <= '0;
      r_shift_cnt <= '0;
      r_tile_cnt  <= '0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_shift_cnt <= '0;
      r_tile_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cfg.n_tiles     <= CFG_CNT_W'(n_tiles_i);
            r_cfg.last_height <= CFG_HGT_W'(last_height_i);
            r_cfg.last_width  <= CFG_CNT_W'(last_width_i);
            r_row_cnt         <= '0;
            r_shift_cnt       <= '0;
            r_tile_cnt        <= '0;
            r_state           <= (n_tiles_i == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (buf_load_o) begin
            if (r_row_cnt == HW'(H - 1)) begin
              r_row_cnt <= '0;
              r_state   <= STREAM;
            end else begin
              r_row_cnt <= r_row_cnt + HW'(1);
            end
          end
        end
        STREAM: begin
          if (shift_gnt_o) begin
            if (r_shift_cnt == DW'(D - 1)) begin
              r_shift_cnt <= '0;
              r_tile_cnt  <= r_tile_cnt + CNT_W'(1);
              r_state     <= w_last_tile ? DONE : FILL;
            end else begin
              r_shift_cnt <= r_shift_cnt + DW'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef REDMULE_W_SCHED_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (w_fill && !w_valid_i) || (w_stream && !shift_req_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clear_i || w_start) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_redmule_w_sched.sv
// Scoreboard bench for redmule_w_sched (H=4, D=8): directed jobs push expected buffer events,
// a negedge monitor pops and compares each load/shift/done the scheduler presents.
module tb_redmule_w_sched;

  localparam int unsigned TH  = 4;
  localparam int unsigned TD  = 8;
  localparam int unsigned TCW = 16;
  localparam int unsigned THW = $clog2(TH) + 1;

  localparam int EV_LOAD  = 0;
  localparam int EV_SHIFT = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int h;
    int w;
  } exp_t;

  logic           clk_i;
  logic           rst_ni;
  logic           clear_i;
  logic           start_i;
  logic [TCW-1:0] n_tiles_i;
  logic [THW-1:0] last_height_i;
  logic [TCW-1:0] last_width_i;
  logic           w_valid_i;
  logic           w_ready_o;
  logic           shift_req_i;
  logic           shift_gnt_o;
  logic           buf_load_o;
  logic           buf_shift_o;
  logic           buf_clear_o;
  logic [THW-1:0] buf_height_o;
  logic [TCW-1:0] buf_width_o;
  logic           busy_o;
  logic           done_o;
  logic [31:0]    stall_cnt_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  redmule_w_sched #(
    .H     (TH),
    .D     (TD),
    .CNT_W (TCW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .n_tiles_i     (n_tiles_i),
    .last_height_i (last_height_i),
    .last_width_i  (last_width_i),
    .w_valid_i     (w_valid_i),
    .w_ready_o     (w_ready_o),
    .shift_req_i   (shift_req_i),
    .shift_gnt_o   (shift_gnt_o),
    .buf_load_o    (buf_load_o),
    .buf_shift_o   (buf_shift_o),
    .buf_clear_o   (buf_clear_o),
    .buf_height_o  (buf_height_o),
    .buf_width_o   (buf_width_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int h, input int w);
    exp_t e;
    e.kind = kind;
    e.h    = h;
    e.w    = w;
    exp_q.push_back(e);
  endtask

  task automatic push_tile(input int h, input int w);
    for (int i = 0; i < TH; i++) push_ev(EV_LOAD, h, w);
    for (int i = 0; i < TD; i++) push_ev(EV_SHIFT, h, w);
  endtask

  // Compares one presented event against the head of the scoreboard.
  task automatic score(input int kind);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        n_errors++;
        $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
      end else if (kind != EV_DONE) begin
        check("event_height", 32'(buf_height_o), 32'(e.h));
        check("event_width", 32'(buf_width_o), 32'(e.w));
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (buf_load_o)  score(EV_LOAD);
      if (buf_shift_o) score(EV_SHIFT);
      if (done_o)      score(EV_DONE);
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    check("start_buf_clear", 32'(buf_clear_o), 32'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Counts cycles (from the first cycle after start) until done_o, bounded.
  task automatic wait_done(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!done_o && k < max);
    if (!done_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, expected done_o", max);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int nd;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    n_tiles_i = '0; last_height_i = '0; last_width_i = '0;
    w_valid_i = 1'b0; shift_req_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_w_ready", 32'(w_ready_o), 0);
    check("rst_height", 32'(buf_height_o), 0);
    check("rst_width", 32'(buf_width_o), 0);
    check("rst_stall", stall_cnt_o, 0);
    #7 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single tile, free-running handshakes: done 13 cycles after start
    n_tiles_i = 1; last_height_i = 4; last_width_i = 8;
    w_valid_i = 1'b1; shift_req_i = 1'b1;
    push_tile(4, 8); push_ev(EV_DONE, 0, 0);
    pulse_start();
    wait_done(40, k);
    check("t1_done_cycle", k, 13);
    @(negedge clk_i);
    check("t1_idle_busy", 32'(busy_o), 0);
    check("t1_idle_done", 32'(done_o), 0);
    @(posedge clk_i); #1;

    // Three tiles, short final tile
    n_tiles_i = 3; last_height_i = 2; last_width_i = 5;
    push_tile(4, 8); push_tile(4, 8); push_tile(2, 5); push_ev(EV_DONE, 0, 0);
    pulse_start();
    wait_done(200, k);
    check("t2_done_cycle", k, 37);
    @(posedge clk_i); #1;

    // Toggling w_valid in FILL, shift_req held high, ignored restart in STREAM
    n_tiles_i = 1; last_height_i = 4; last_width_i = 8;
    w_valid_i = 1'b0;
    push_tile(4, 8); push_ev(EV_DONE, 0, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      w_valid_i = pat[i];
      @(negedge clk_i);
      check("t3_load", 32'(buf_load_o), 32'(pat[i]));
      check("t3_fill_no_gnt", 32'(shift_gnt_o), 0);
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b1;
    @(negedge clk_i);
    check("t3_stream_gnt", 32'(shift_gnt_o), 1);
`ifdef REDMULE_W_SCHED_PERF_EN
    check("t3_stall_after_fill", stall_cnt_o, 2);
`endif
    @(posedge clk_i); #1;
    start_i = 1'b1; n_tiles_i = 5;
    @(negedge clk_i);
    check("t3_restart_no_clear", 32'(buf_clear_o), 0);
    check("t3_restart_width", 32'(buf_width_o), 8);
    @(posedge clk_i); #1;
    start_i = 1'b0; n_tiles_i = 1;
    wait_done(40, k);
    check("t3_done_cycle", k, 7);
`ifdef REDMULE_W_SCHED_PERF_EN
    check("t3_stall_kept", stall_cnt_o, 2);
`endif
    @(posedge clk_i); #1;

    // clear_i on the 3rd shift of tile 0
    n_tiles_i = 2; last_height_i = 3; last_width_i = 6;
    for (int i = 0; i < TH; i++) push_ev(EV_LOAD, 4, 8);
    push_ev(EV_SHIFT, 4, 8); push_ev(EV_SHIFT, 4, 8);
    pulse_start();
    repeat (6) @(posedge clk_i);
    #1;
    clear_i = 1'b1;
    @(negedge clk_i);
    check("t4_clear_buf_clear", 32'(buf_clear_o), 1);
    check("t4_clear_no_shift", 32'(buf_shift_o), 0);
    check("t4_clear_busy", 32'(busy_o), 1);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    check("t4_idle_busy", 32'(busy_o), 0);
    check("t4_idle_ready", 32'(w_ready_o), 0);
    count_done(20, nd);
    check("t4_no_done", nd, 0);
    @(posedge clk_i); #1;

    // Zero-tile job
    n_tiles_i = 0;
    push_ev(EV_DONE, 0, 0);
    start_i = 1'b1;
    @(negedge clk_i);
    check("t5_start_clear", 32'(buf_clear_o), 1);
    check("t5_start_busy", 32'(busy_o), 0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("t5_busy", 32'(busy_o), 1);
    check("t5_done", 32'(done_o), 1);
    check("t5_no_load", 32'(buf_load_o), 0);
    @(negedge clk_i);
    check("t5_after_busy", 32'(busy_o), 0);
    check("t5_after_done", 32'(done_o), 0);
    @(posedge clk_i); #1;

    // Asynchronous reset mid-fill abandons the job
    n_tiles_i = 1; last_height_i = 4; last_width_i = 8;
    push_ev(EV_LOAD, 4, 8); push_ev(EV_LOAD, 4, 8);
    pulse_start();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_ready", 32'(w_ready_o), 0);
    check("t6_rst_height", 32'(buf_height_o), 0);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    count_done(20, nd);
    check("t6_no_done", nd, 0);

    repeat (2) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
